room_status_tx: RTL

Serial status transmitter for the room lighting controller. It snapshots the controller's per-room light state, occupied-room count and eight 4-bit countdown timers, then sends them to the building panel as a fixed 8-byte frame. The line format is UART 8N1, LSB first, and the frame ends with an XOR checksum. It sits downstream of the controller and drives the single wire that the panel-side receiver listens on.

---
 rtl/room_pkg.sv | 7 +
 rtl/room_status_tx_if.sv | 23 ++
 rtl/room_byte_tx.sv | 57 +++++
 rtl/room_status_tx.sv | 56 +++++
 4 files changed

// File: rtl/room_pkg.sv
// room_pkg: shared constants and state encoding for the room status transmitter
package room_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_BYTES = 8;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/room_status_tx_if.sv
// room_status_tx_if: controller snapshot inputs and serial status outputs
interface room_status_tx_if;
  logic start;
  logic [7:0] lightson;
  logic [3:0] count;
  logic [3:0] countdown0, countdown1, countdown2, countdown3;
  logic [3:0] countdown4, countdown5, countdown6, countdown7;
  logic tx;
  logic busy;
  logic frame_done;
  modport master(
    output start, lightson, count,
    output countdown0, countdown1, countdown2, countdown3,
    output countdown4, countdown5, countdown6, countdown7,
    input tx, busy, frame_done
  );
  modport slave(
    input start, lightson, count,
    input countdown0, countdown1, countdown2, countdown3,
    input countdown4, countdown5, countdown6, countdown7,
    output tx, busy, frame_done
  );
endinterface

// File: rtl/room_byte_tx.sv
// room_byte_tx: 8N1 byte serializer, accepts the next byte in the last stop-bit cycle
module room_byte_tx
  import room_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       done_o
);
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        tx_q;
  logic        tick;
  assign tick    = cnt_q == 16'(CLKS_PER_BIT - 1);
  assign done_o  = state_q == STOP && tick;
  assign ready_o = state_q == IDLE || done_o;
  assign tx_o    = tx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else if (load_i && ready_o) begin
      state_q <= START;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= data_i;
      tx_q    <= 1'b0;
    end else if (state_q != IDLE) begin
      cnt_q <= tick ? '0 : cnt_q + 16'd1;
      if (tick) begin
        if (state_q == START) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
        end else if (state_q == DATA && bit_q != 3'd7) begin
          bit_q <= bit_q + 3'd1;
          tx_q  <= sh_q[0];
          sh_q  <= sh_q >> 1;
        end else if (state_q == DATA) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end else begin
          state_q <= IDLE;
        end
      end
    end
endmodule

// File: rtl/room_status_tx.sv
// room_status_tx: snapshots room state and sends it as an 8-byte checksummed 8N1 frame
module room_status_tx
  import room_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic              clk,
  input logic              rst,
  room_status_tx_if.slave  bus
);
  logic [5:0][7:0] snap_q, snap_d;
  logic [7:0]      csum_q, csum_d, byte_d;
  logic [2:0]      idx_q;
  logic            active_q, pend_q, done_q, pend_d;
  logic            ser_done, ser_ready, go, nxt, frame_end, load;
  always_comb begin
    frame_end = ser_done && idx_q == LAST_BYTE;
    go        = frame_end ? (pend_q || bus.start) : (bus.start && !active_q);
    nxt       = ser_done && !frame_end;
    load      = ser_ready && (go || nxt);
    byte_d    = go ? SYNC_BYTE : idx_q == LAST_BYTE - 3'd1 ? csum_q : snap_q[idx_q];
    csum_d    = go ? 8'h00 : (nxt && idx_q != LAST_BYTE - 3'd1) ? csum_q ^ snap_q[idx_q] : csum_q;
    pend_d    = frame_end ? (pend_q && bus.start) : (pend_q || (bus.start && active_q));
    snap_d    = go ? {bus.countdown7, bus.countdown6, bus.countdown5, bus.countdown4,
                      bus.countdown3, bus.countdown2, bus.countdown1, bus.countdown0,
                      4'h0, bus.count, bus.lightson} : snap_q;
  end
  // idx_q names the byte on the wire; it wraps to 0 as the last byte finishes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap_q   <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      csum_q   <= csum_d;
      idx_q    <= ser_done ? idx_q + 3'd1 : idx_q;
      active_q <= go ? 1'b1 : frame_end ? 1'b0 : active_q;
      pend_q   <= pend_d;
      done_q   <= frame_end;
    end
  assign bus.busy       = active_q;
  assign bus.frame_done = done_q;
  room_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i (byte_d),
    .ready_o(ser_ready),
    .tx_o   (bus.tx),
    .done_o (ser_done)
  );
endmodule
